jump_ctrl: RTL
==============

JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive synchronized-high cycles required to accept a press.
REQ-002 Parameter JUMP_LEN, default 51: number of height-table entries in one jump arc (1..1023).
REQ-003 Parameter ADDR_W, default 10: width of the jump-table address.
REQ-004 Clocking: single clock domain; `reset` is synchronous and active-high.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port btn_raw, input, 1: asynchronous raw jump button, active-high.
REQ-008 Port gs, input, 1: game-started flag; 0 = game not running.
REQ-009 Port halt, input, 1: game frozen (collision/pause); 1 = freeze.
REQ-010 Port movaddr, input, ADDR_W: current height-table address from the downstream movement stage.
REQ-011 Port jump_en, output, 1: level to the movement stage's button input; high for the whole arc.
REQ-012 Port mov_reset, output, 1: one-cycle pulse that clears the movement stage's timing counters.
REQ-013 Port jumping, output, 1: status; high in state JUMP.
REQ-014 Port jump_count, output, 8: number of completed jumps, saturating at 255.

Function
REQ-015 btn_raw SHALL pass through a 2-flop synchronizer; only the second-flop output (btn_s) SHALL be used.
REQ-016 FSM states SHALL be IDLE, ARMED, JUMP and RELEASE; all outputs SHALL be registered.
REQ-017 IDLE: debounce counter held at 0; if btn_s=1, go to ARMED.
REQ-018 ARMED: counter increments each cycle while btn_s=1.
REQ-019 ARMED: if btn_s=0, return to IDLE with counter cleared.
REQ-020 ARMED: when the counter reaches DEBOUNCE_CYCLES-1 with btn_s=1, go to JUMP, latch start_addr<=movaddr, and assert mov_reset for one cycle.
REQ-021 JUMP: jump_en=1 and jumping=1.
REQ-022 JUMP: offset = (movaddr - start_addr) mod 2^ADDR_W, i.e. wrap-around subtraction in ADDR_W bits.
REQ-023 JUMP: when offset >= JUMP_LEN, go to RELEASE, drive jump_en=0 the next cycle, pulse mov_reset for one cycle, and increment jump_count unless it is at 255.
REQ-024 Button activity during JUMP SHALL be ignored; there is no double jump and the arc is not extended.
REQ-025 RELEASE: stay until btn_s=0 for one cycle, then go to IDLE; a held button SHALL never auto-repeat.
REQ-026 halt=1 SHALL freeze the state, debounce counter, start_addr and jump_count, and SHALL force jump_en=0.
REQ-027 On halt falling, JUMP SHALL resume with jump_en=1 and the same start_addr.
REQ-028 gs=0 in any state SHALL force IDLE next cycle, clear the counter, and drive jump_en=0 and jumping=0; jump_count is kept.
REQ-029 Precedence SHALL be reset > gs=0 > halt > normal operation.
REQ-030 If the JUMP exit condition and halt=1 occur in the same cycle, halt SHALL win and the exit SHALL be evaluated after halt is released.
REQ-031 mov_reset SHALL never be high for two consecutive cycles.

Reset
REQ-032 On reset: state=IDLE; synchronizer flops, debounce counter and start_addr = 0; jump_en=0, mov_reset=0, jumping=0, jump_count=0.
REQ-033 Reset asserted mid-JUMP SHALL take effect on the next clock edge with no mov_reset pulse.

Verification (DEBOUNCE_CYCLES=4, JUMP_LEN=51, ADDR_W=10)
REQ-034 Clean press, gs=1, halt=0, btn_raw high 10 cycles -> state JUMP; jump_en rises 2 (sync) + 4 cycles after btn_raw rise; one mov_reset pulse; start_addr latched.
REQ-035 Glitch, btn_raw high 3 cycles then low -> never enters JUMP; jump_en stays 0; counter returns to 0.
REQ-036 Wrap: start_addr=1000, movaddr steps 1000..1023,0..26 -> exit when movaddr=27 (offset 51); jump_count 0->1; one mov_reset pulse.
REQ-037 Held button: btn_raw held through and after landing -> stays in RELEASE with no second jump; after 1 low cycle + 4 high cycles (plus sync) a second jump starts.
REQ-038 Halt mid-JUMP at offset 20 for 100 cycles -> jump_en=0 during halt; after halt falls, state JUMP, same start_addr, jump_en=1.
REQ-039 gs drops mid-JUMP -> IDLE next cycle, jump_en=0, jump_count unchanged; reset mid-JUMP -> all outputs 0, no mov_reset pulse.

Source files
------------

// File: rtl/jump_ctrl_if.sv
// Jump controller bus: button/game-status inputs and jump outputs toward the movement stage.
// The testbench or game top drives the master side; jump_ctrl is the slave.
interface jump_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              btn_raw;
  logic              gs;
  logic              halt;
  logic [ADDR_W-1:0] movaddr;
  logic              jump_en;
  logic              mov_reset;
  logic              jumping;
  logic [7:0]        jump_count;

  modport master (
    output btn_raw, gs, halt, movaddr,
    input  jump_en, mov_reset, jumping, jump_count
  );

  modport slave (
    input  btn_raw, gs, halt, movaddr,
    output jump_en, mov_reset, jumping, jump_count
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump button controller: synchronizes and debounces the raw button, then runs one jump arc
// measured against the movement stage's height-table address, with halt/game-stop overrides.
module jump_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int JUMP_LEN        = 51,
  parameter int ADDR_W          = 10
) (
  input  logic     clk,
  input  logic     reset,
  jump_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ARC_LEN  = ADDR_W'(JUMP_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    JUMP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic              r_sync1, r_sync2;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_cnt_inc;
  logic [ADDR_W-1:0] r_start, w_start_nx, w_offset;
  logic [7:0]        r_count, w_count_nx;
  logic              r_jump_en, w_jump_en_nx;
  logic              r_mov_reset, w_mov_reset_nx;
  logic              r_jumping, w_jumping_nx;

  // Two-flop synchronizer; only r_sync2 feeds the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_offset  = bus.movaddr - r_start;

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_start_nx     = r_start;
    w_count_nx     = r_count;
    w_mov_reset_nx = 1'b0;

    if (!bus.gs) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else if (!bus.halt) begin
      case (r_state)
        IDLE: begin
          w_cnt_nx = '0;
          if (r_sync2) w_state_nx = ARMED;
        end
        ARMED: begin
          if (!r_sync2) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else if (w_cnt_inc >= CNT_LAST) begin
            w_state_nx     = JUMP;
            w_cnt_nx       = '0;
            w_start_nx     = bus.movaddr;
            w_mov_reset_nx = 1'b1;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        JUMP: begin
          // Holding off while the entry pulse is still out keeps mov_reset from doubling up
          if ((w_offset >= ARC_LEN) && !r_mov_reset) begin
            w_state_nx     = RELEASE;
            w_mov_reset_nx = 1'b1;
            if (r_count != 8'hFF) w_count_nx = r_count + 8'd1;
          end
        end
        RELEASE: begin
          if (!r_sync2) w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end

    w_jumping_nx = (w_state_nx == JUMP);
    w_jump_en_nx = bus.gs && !bus.halt && (w_state_nx == JUMP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_start     <= '0;
      r_count     <= '0;
      r_jump_en   <= 1'b0;
      r_mov_reset <= 1'b0;
      r_jumping   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_start     <= w_start_nx;
      r_count     <= w_count_nx;
      r_jump_en   <= w_jump_en_nx;
      r_mov_reset <= w_mov_reset_nx;
      r_jumping   <= w_jumping_nx;
    end
  end

  assign bus.jump_en    = r_jump_en;
  assign bus.mov_reset  = r_mov_reset;
  assign bus.jumping    = r_jumping;
  assign bus.jump_count = r_count;

endmodule
